// File: rtl/psum_spad_ctrl.sv
// Partial-sum scratchpad controller: read-modify-write accumulate (4 cycles per request), clear, and drain.
// Drain holds out_valid/out_addr/out_data until out_ready; PSUM_SAT_EN selects saturating instead of wrapping adds.
module psum_spad_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 5,
  parameter int DEPTH = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_valid,
  output logic          acc_ready,
  input  logic [AW-1:0] acc_addr,
  input  logic [DW-1:0] acc_data,
  input  logic          acc_first,
  input  logic          clr_start,
  input  logic          drain_start,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          err_addr,
  output logic [AW-1:0] spad_addr,
  output logic          spad_we,
  inout  logic [DW-1:0] spad_data
);

  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, A_RD, A_CAP, A_WR, D_RD, D_CAP, D_OUT, CLR
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] tgt_addr;
  logic [DW-1:0] tgt_data;
  logic          tgt_first;
  logic [DW-1:0] cap;
  logic [AW-1:0] idx;
  logic [AW-1:0] last_addr;
  logic          err_q;

  logic          ready_c;
  logic          we_c;
  logic [AW-1:0] addr_c;
  logic [DW-1:0] wdata;
  logic [DW-1:0] sum;
  logic          cap_en;
  logic          take;
  logic          err_set;
  logic          idx_inc;
  logic          idx_clr;
  logic          in_range;

  assign in_range = ({1'b0, acc_addr} < DEPTH_W);

`ifdef PSUM_SAT_EN
  logic [DW:0] sum_ext;

  // One extra bit exposes signed overflow: the top two bits disagree.
  always_comb begin
    sum_ext = {cap[DW-1], cap} + {tgt_data[DW-1], tgt_data};
    if (sum_ext[DW] != sum_ext[DW-1]) begin
      sum = sum_ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      sum = sum_ext[DW-1:0];
    end
  end
`else
  assign sum = cap + tgt_data;
`endif

  always_comb begin
    state_n = state;
    ready_c = 1'b0;
    we_c    = 1'b0;
    addr_c  = last_addr;
    wdata   = '0;
    cap_en  = 1'b0;
    take    = 1'b0;
    err_set = 1'b0;
    idx_inc = 1'b0;
    idx_clr = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_n = CLR;
        end else if (drain_start) begin
          state_n = D_RD;
        end else begin
          ready_c = 1'b1;
          if (acc_valid) begin
            take = 1'b1;
            if (in_range) state_n = A_RD;
            else          err_set = 1'b1;
          end
        end
      end
      A_RD: begin
        addr_c  = tgt_addr;
        state_n = A_CAP;
      end
      A_CAP: begin
        addr_c  = tgt_addr;
        cap_en  = 1'b1;
        state_n = A_WR;
      end
      A_WR: begin
        addr_c  = tgt_addr;
        we_c    = 1'b1;
        wdata   = tgt_first ? tgt_data : sum;
        state_n = IDLE;
      end
      D_RD: begin
        addr_c  = idx;
        state_n = D_CAP;
      end
      D_CAP: begin
        addr_c  = idx;
        cap_en  = 1'b1;
        state_n = D_OUT;
      end
      D_OUT: begin
        addr_c    = idx;
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx == LAST) begin
            idx_clr = 1'b1;
            state_n = IDLE;
          end else begin
            idx_inc = 1'b1;
            state_n = D_RD;
          end
        end
      end
      CLR: begin
        addr_c = idx;
        we_c   = 1'b1;
        if (idx == LAST) begin
          idx_clr = 1'b1;
          state_n = IDLE;
        end else begin
          idx_inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tgt_addr  <= '0;
      tgt_data  <= '0;
      tgt_first <= 1'b0;
      cap       <= '0;
      idx       <= '0;
      last_addr <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      last_addr <= addr_c;
      if (take && in_range) begin
        tgt_addr  <= acc_addr;
        tgt_data  <= acc_data;
        tgt_first <= acc_first;
      end
      if (err_set) err_q <= 1'b1;
      if (cap_en)  cap   <= spad_data;
      if (idx_clr) idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
    end
  end

  // Reset gates the write strobe combinationally so an aborted A_WR or CLR never lands.
  assign spad_we   = we_c & ~rst;
  assign acc_ready = ready_c & ~rst;
  assign spad_addr = addr_c;
  assign spad_data = spad_we ? wdata : {DW{1'bz}};
  assign busy      = (state != IDLE);
  assign out_addr  = idx;
  assign out_data  = cap;
  assign err_addr  = err_q;

endmodule

// File: tb/tb_psum_spad_ctrl.sv
// Bench for psum_spad_ctrl with a registered-read scratchpad model on the shared bus.
module tb_psum_spad_ctrl;
  localparam int DW = 16;
  localparam int AW = 5;
  localparam int DEPTH = 24;

  logic          clk = 1'b0;
  logic          rst, acc_valid, acc_first, clr_start, drain_start, out_ready;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_data;
  logic          acc_ready, busy, out_valid, err_addr, spad_we;
  logic [AW-1:0] out_addr, spad_addr;
  logic [DW-1:0] out_data;
  wire  [DW-1:0] spad_data;

  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;
  int bad_addr = 0;

  psum_spad_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_addr(acc_addr),
    .acc_data(acc_data), .acc_first(acc_first),
    .clr_start(clr_start), .drain_start(drain_start), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .err_addr(err_addr),
    .spad_addr(spad_addr), .spad_we(spad_we), .spad_data(spad_data)
  );

  always #5 clk = ~clk;

  // Scratchpad: writes land at the edge, reads return one cycle later.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd_q;
  logic          mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'hA500 + 16'(i);
    end else if (spad_we) begin
      mem[spad_addr] <= spad_data;
    end else begin
      rd_q <= mem[spad_addr];
    end
  end
  assign spad_data = spad_we ? 16'bz : rd_q;

  always @(posedge clk) begin
    if (spad_we) we_cnt <= we_cnt + 1;
    if (!mem_init && spad_addr >= 5'(DEPTH)) bad_addr <= bad_addr + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting, expected event", nm);
  endtask

  typedef struct {
    logic          rst, av;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          first, clr, drn;
    logic          e_rdy, e_busy, e_we;
    logic [AW-1:0] e_saddr;
    logic          e_ov, e_err;
  } vec_t;

  vec_t tv[14];
  logic [DW-1:0] exp_v[DEPTH];

  task automatic do_acc(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic f);
    int n;
    @(negedge clk);
    acc_valid = 1'b1; acc_addr = a; acc_data = d; acc_first = f;
    #1;
    n = 0;
    while (!acc_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) timeout("acc_handshake");
    @(negedge clk);
    acc_valid = 1'b0;
    #1;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) timeout("acc_done");
  endtask

  task automatic do_clear();
    int n, w;
    @(negedge clk); clr_start = 1'b1;
    @(negedge clk); clr_start = 1'b0;
    #1;
    n = 0; w = 0;
    while (busy && n < 40) begin
      if (spad_we) w++;
      @(negedge clk); #1; n++;
    end
    if (n >= 40) timeout("clear_done");
    check("clear_write_cycles", 32'(w), 32'(DEPTH));
  endtask

  task automatic do_drain();
    int n;
    @(negedge clk); drain_start = 1'b1; out_ready = 1'b1;
    @(negedge clk); drain_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      out_ready = (i != 7);
      #1;
      n = 0;
      while (!out_valid && n < 10) begin @(negedge clk); #1; n++; end
      if (n >= 10) begin
        timeout($sformatf("drain_entry%0d", i));
        return;
      end
      check($sformatf("drain%0d.addr", i), 32'(out_addr), 32'(i));
      check($sformatf("drain%0d.data", i), 32'(out_data), 32'(exp_v[i]));
      if (i == 7) begin
        repeat (4) begin
          @(negedge clk); #1;
          check("stall.valid", 32'(out_valid), 32'd1);
          check("stall.addr", 32'(out_addr), 32'd7);
          check("stall.data", 32'(out_data), 32'(exp_v[7]));
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    #1;
    check("drain_end.busy", 32'(busy), 32'd0);
    check("drain_end.valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int we0;
    //        rst   av    addr   data      first clr   drn  | rdy   busy  we    saddr  ov    err
    tv[0]  = '{1'b1, 1'b1, 5'd3,  16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 1'b1, 5'd3,  16'h0005, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 5'd3,  16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 1'b1, 5'd3,  16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 1'b1, 5'd3,  16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 5'd3,  16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 1'b1, 5'd24, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 5'd24, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 1'b1, 5'd24, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 1'b1, 5'd24, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0};
    tv[10] = '{1'b0, 1'b1, 5'd3,  16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1};
    tv[11] = '{1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1};
    tv[12] = '{1'b1, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 1'b1};
    tv[13] = '{1'b0, 1'b0, 5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0};

    for (int i = 0; i < DEPTH; i++) exp_v[i] = '0;
    exp_v[0]  = 16'h0011;
    exp_v[3]  = 16'h0003;
    exp_v[10] = 16'hFFFC;
    exp_v[23] = 16'h1235;
`ifdef PSUM_SAT_EN
    exp_v[5] = 16'h7FFF;
    exp_v[6] = 16'h8000;
`else
    exp_v[5] = 16'h8000;
    exp_v[6] = 16'h7FFF;
`endif

    mem_init = 1'b1;
    rst = 1'b1; acc_valid = 1'b0; acc_addr = '0; acc_data = '0; acc_first = 1'b0;
    clr_start = 1'b0; drain_start = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;

    for (int i = 0; i < 14; i++) begin
      rst = tv[i].rst; acc_valid = tv[i].av; acc_addr = tv[i].addr; acc_data = tv[i].data;
      acc_first = tv[i].first; clr_start = tv[i].clr; drain_start = tv[i].drn;
      #1;
      check($sformatf("v%0d.acc_ready", i), 32'(acc_ready), 32'(tv[i].e_rdy));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(tv[i].e_busy));
      check($sformatf("v%0d.spad_we", i), 32'(spad_we), 32'(tv[i].e_we));
      check($sformatf("v%0d.spad_addr", i), 32'(spad_addr), 32'(tv[i].e_saddr));
      check($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(tv[i].e_ov));
      check($sformatf("v%0d.err_addr", i), 32'(err_addr), 32'(tv[i].e_err));
      @(negedge clk);
    end
    check("post_table.out_addr", 32'(out_addr), 32'd0);
    check("post_table.out_data", 32'(out_data), 32'd0);

    do_clear();

    we0 = we_cnt;
    do_acc(5'd0,  16'h0011, 1'b1);
    do_acc(5'd3,  16'h0005, 1'b1);
    do_acc(5'd3,  16'hFFFE, 1'b0);
    do_acc(5'd5,  16'h7FFF, 1'b1);
    do_acc(5'd5,  16'h0001, 1'b0);
    do_acc(5'd6,  16'h8000, 1'b1);
    do_acc(5'd6,  16'hFFFF, 1'b0);
    do_acc(5'd10, 16'hFFF9, 1'b1);
    do_acc(5'd10, 16'h0003, 1'b0);
    do_acc(5'd23, 16'h1234, 1'b1);
    do_acc(5'd23, 16'h0001, 1'b0);
    check("acc_write_count", 32'(we_cnt - we0), 32'd11);

    // Reset lands while the accumulate sits in A_CAP.
    we0 = we_cnt;
    @(negedge clk);
    acc_valid = 1'b1; acc_addr = 5'd3; acc_data = 16'd50; acc_first = 1'b0;
    #1;
    check("rstcap.acc_ready", 32'(acc_ready), 32'd1);
    @(negedge clk);
    acc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstcap.we_in_cap", 32'(spad_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstcap.busy", 32'(busy), 32'd0);
    check("rstcap.spad_we", 32'(spad_we), 32'd0);
    check("rstcap.spad_addr", 32'(spad_addr), 32'd0);
    repeat (3) @(negedge clk);
    check("rstcap.no_write", 32'(we_cnt - we0), 32'd0);

    we0 = we_cnt;
    do_acc(5'd24, 16'd100, 1'b0);
    check("oor.err_addr", 32'(err_addr), 32'd1);
    check("oor.no_write", 32'(we_cnt - we0), 32'd0);

    do_drain();
    check("no_addr_beyond_depth", 32'(bad_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_spad_ctrl.md
PSUM_SPAD_CTRL -- requirements
Module: psum_spad_ctrl

Interface
REQ-001 Parameter DW, default 16, psum data width (two's complement).
REQ-002 Parameter AW, default 5, scratchpad address width.
REQ-003 Parameter DEPTH, default 24, number of valid psum entries (0..DEPTH-1).
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 acc_valid / acc_ready  in / out  1 / 1  accumulate request handshake; transfer on a cycle where both are 1.
REQ-007 acc_addr  in  AW  target psum entry.
REQ-008 acc_data  in  DW  signed partial product to add.
REQ-009 acc_first  in  1  1 = overwrite the entry with acc_data, no add.
REQ-010 clr_start  in  1  pulse; zero all DEPTH entries.
REQ-011 drain_start  in  1  pulse; stream out all entries, address 0 to DEPTH-1.
REQ-012 busy  out  1  1 whenever state is not IDLE.
REQ-013 out_valid / out_ready  out / in  1 / 1  drain output handshake.
REQ-014 out_addr / out_data  out  AW / DW  drained entry index and value.
REQ-015 err_addr  out  1  sticky; set by an out-of-range acc_addr.
REQ-016 spad_addr / spad_we  out  AW / 1  to scratchpad; spad_we 0 = read, 1 = write.
REQ-017 spad_data  inout  DW  shared bus; the controller SHALL drive it only when spad_we=1 and SHALL float it otherwise.

Function
REQ-018 Scratchpad model: a read is registered. With spad_we=0 and addr A at edge N, mem[A] appears on spad_data during cycle N+1 for as long as spad_we stays 0. A write takes effect at the edge where spad_we=1.
REQ-019 States: IDLE, A_RD, A_CAP, A_WR, D_RD, D_CAP, D_OUT, CLR.
REQ-020 acc_ready SHALL be 1 only in IDLE when no clr_start or drain_start is asserted in the same cycle.
REQ-021 Arbitration in IDLE, fixed priority: clr_start, then drain_start, then acc_valid. A start pulse seen outside IDLE SHALL be ignored.
REQ-022 Accumulate, in range (acc_addr < DEPTH):
- IDLE to A_RD on transfer; addr, data and first are latched.
- A_RD: spad_addr = latched addr, spad_we = 0.
- A_CAP: spad_we = 0; spad_data is captured.
- A_WR: spad_we = 1; spad_data = captured + data, or data alone if first; then IDLE.
- Total occupancy: 3 cycles after the handshake.
REQ-023 Accumulate, out of range: transfer accepted, no scratchpad access, err_addr set, state stays IDLE.
REQ-024 The add is DW-bit with wrap-around unless PSUM_SAT_EN is defined (see Configuration).
REQ-025 Drain, per entry i from 0 to DEPTH-1:
- D_RD issues the read; D_CAP captures the value.
- D_OUT holds out_valid=1, out_addr=i, out_data=value, all stable until out_ready.
- On handshake: i = DEPTH-1 goes to IDLE; otherwise i+1 and back to D_RD.
REQ-026 Clear: in CLR, spad_we=1 and spad_data=0 for addresses 0..DEPTH-1, one per cycle (DEPTH cycles), then IDLE.
REQ-027 Outside the states that drive them, spad_we=0 and spad_addr holds its last value. Addresses >= DEPTH SHALL never be issued.
REQ-028 out_valid SHALL be 0 in every state except D_OUT.

Reset
REQ-029 When rst=1 at an edge:
- state becomes IDLE and all counters are 0;
- spad_we=0, spad_addr=0, out_valid=0, out_addr=0, out_data=0, err_addr=0, busy=0.
REQ-030 Reset during any operation SHALL abort it immediately; no further scratchpad write SHALL be issued.
REQ-031 acc_ready SHALL be 0 while rst=1.

Configuration
REQ-032 Macro PSUM_SAT_EN:
- Defined: a signed add overflow SHALL clamp to 2^(DW-1)-1 or -2^(DW-1).
- Undefined: the sum wraps modulo 2^DW.
- acc_first writes are unaffected either way.

Verification
REQ-033 Clear, then acc to addr 3 with first=1, data=5, then acc addr 3 with data=-2, then drain: entry 3 = 3, every other entry = 0, and 24 outputs in address order.
REQ-034 Back-to-back acc_valid: handshakes occur exactly every 4 cycles, with spad_we=1 only in the third cycle after each handshake.
REQ-035 Entry = 0x7FFF, add 1: result 0x8000 without PSUM_SAT_EN, 0x7FFF with it.
REQ-036 acc_addr=24: transfer accepted, err_addr=1, no spad_we pulse, and the drain shows no changed entry.
REQ-037 Drain with out_ready held 0 for 5 cycles on entry 7: out_data and out_addr stay stable, and the drain then continues to entry 8.
REQ-038 rst asserted in A_CAP: next cycle is IDLE, spad_we=0, and the target entry is unchanged.
